// File: rtl/data_bus_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | data_bus_pkg                                                     |
// | Shared types and constants for the internal data-bus arbiter.    |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
package data_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_ARB    = 1'b1;

  // Ceiling log2, never below 1 so a 1-wide index is always legal.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_pick                                                          |
// | Round-robin winner: first set request above ptr, wrapping.       |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module rr_pick #(
  parameter int NUM_SRC = 6,
  parameter int SEL_W   = data_bus_pkg::clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   winner,
  output logic               any
);

  // The pointer itself is scanned last, so the previous owner only wins alone.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!any && req[(int'(ptr) + k) % NUM_SRC]) begin
        winner = SEL_W'((int'(ptr) + k) % NUM_SRC);
        any    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_bus_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | data_bus_arbiter                                                 |
// | Registered data-bus source selector: direct or round-robin mode. |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module data_bus_arbiter
  import data_bus_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_SRC   = 6,
  parameter int SEL_W     = clog2(NUM_SRC),
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         select_data,
  input  logic                     bus_hold,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]       src_req,
  output logic [NUM_SRC-1:0]       src_gnt,
  output logic [WIDTH-1:0]         out_data_bus,
  output logic                     out_valid,
  output logic [SEL_W-1:0]         out_src
);

  localparam int               CNT_W     = clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   owner_q, owner_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   data_d;
  logic               valid_d;
  logic [SEL_W-1:0]   src_d;

  logic [WIDTH-1:0]   src_arr [NUM_SRC];
  logic [WIDTH-1:0]   sel_val;
  logic [WIDTH-1:0]   owner_val;
  logic [NUM_SRC-1:0] owner_onehot;
  logic               sel_ok;
  logic               owner_req;
  logic               others_req;
  logic [SEL_W-1:0]   pick;
  logic               pick_any;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_arr[i] = src_data[i*WIDTH +: WIDTH];
  end

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_rr_pick (
    .req    (src_req),
    .ptr    (ptr_q),
    .winner (pick),
    .any    (pick_any)
  );

  always_comb begin
    sel_val      = '0;
    owner_val    = '0;
    owner_onehot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (select_data == SEL_W'(i)) sel_val = src_arr[i];
      if (owner_q == SEL_W'(i)) begin
        owner_val       = src_arr[i];
        owner_onehot[i] = 1'b1;
      end
    end
  end

  assign sel_ok     = (int'(select_data) < NUM_SRC);
  assign owner_req  = |(src_req & owner_onehot);
  assign others_req = |(src_req & ~owner_onehot);

  // Grant comes from registered state only, never from src_req.
  assign src_gnt = (state_q == OWN) ? owner_onehot : '0;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = out_data_bus;
    valid_d = 1'b0;
    src_d   = out_src;

    if (bus_hold) begin
      valid_d = 1'b0;
    end else if (mode == MODE_DIRECT) begin
      state_d = IDLE;
      cnt_d   = '0;
      src_d   = select_data;
      if (sel_ok) begin
        data_d  = sel_val;
        valid_d = 1'b1;
      end else begin
        data_d  = '0;
      end
    end else begin
      case (state_q)
        IDLE, TURN: begin
          if (pick_any) begin
            state_d = OWN;
            owner_d = pick;
            ptr_d   = pick;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
        OWN: begin
          if (owner_req) begin
            data_d  = owner_val;
            src_d   = owner_q;
            valid_d = 1'b1;
            if (cnt_q == LAST_BEAT) begin
              cnt_d = '0;
              if (others_req) state_d = TURN;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d   = '0;
            state_d = others_req ? TURN : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      ptr_q        <= SEL_W'(NUM_SRC - 1);
      cnt_q        <= '0;
      out_data_bus <= '0;
      out_valid    <= 1'b0;
      out_src      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      out_data_bus <= data_d;
      out_valid    <= valid_d;
      out_src      <= src_d;
    end
  end

endmodule
`default_nettype wire
